// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, RGB888 colours and the test-bar lookup.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_H_BACK  = 48;
  localparam int unsigned VGA_H_VALID = 640;
  localparam int unsigned VGA_H_TOTAL = 800;
  localparam int unsigned VGA_V_SYNC  = 2;
  localparam int unsigned VGA_V_BACK  = 33;
  localparam int unsigned VGA_V_VALID = 480;
  localparam int unsigned VGA_V_TOTAL = 525;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb888_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb888_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb888_t RGB_GREEN   = 24'h00FF00;
  localparam rgb888_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb888_t RGB_RED     = 24'hFF0000;
  localparam rgb888_t RGB_BLUE    = 24'h0000FF;
  localparam rgb888_t RGB_BLACK   = 24'h000000;

  // Eight 80-pixel bars: x/80 == (x>>4)/5, so compare x>>4 against multiples of 5.
  function automatic rgb888_t bar_colour(input logic [COORD_W-1:0] x);
    logic [5:0] q;
    q = 6'(x >> 4);
    if      (q < 6'd5)  return RGB_WHITE;
    else if (q < 6'd10) return RGB_YELLOW;
    else if (q < 6'd15) return RGB_CYAN;
    else if (q < 6'd20) return RGB_GREEN;
    else if (q < 6'd25) return RGB_MAGENTA;
    else if (q < 6'd30) return RGB_RED;
    else if (q < 6'd35) return RGB_BLUE;
    else                return RGB_BLACK;
  endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// vga_sync_cnt: wrapping position counter with sync-pulse and active-window decode.
module vga_sync_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL    = VGA_H_TOTAL,
  parameter int unsigned SYNC     = VGA_H_SYNC,
  parameter int unsigned START    = VGA_H_SYNC + VGA_H_BACK,
  parameter int unsigned VALID    = VGA_H_VALID,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               sync_c,
  output logic               act_c
);

  localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] SYNC_W  = COORD_W'(SYNC);
  localparam logic [COORD_W-1:0] START_W = COORD_W'(START);
  localparam logic [COORD_W-1:0] END_W   = COORD_W'(START + VALID);

  // Count 0..TOTAL-1 while enabled, wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + COORD_W'(1);
  end

  assign sync_c = (cnt < SYNC_W) ? SYNC_POL : ~SYNC_POL;
  assign act_c  = (cnt >= START_W) && (cnt < END_W);

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 timing generator, one-ahead pixel requester and output register.
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_en and an eight-bar test pattern.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned H_VALID  = VGA_H_VALID,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter int unsigned V_VALID  = VGA_V_VALID,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  rgb888_t            pos_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_en,
`endif
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pix_req,
  output logic               hsync,
  output logic               vsync,
  output logic               vga_de,
  output rgb888_t            rgb,
  output logic               frame_start
);

  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_REQ_LO  = COORD_W'(H_START - 1);
  localparam logic [COORD_W-1:0] H_REQ_HI  = COORD_W'(H_START + H_VALID - 1);
  localparam logic [COORD_W-1:0] H_START_W = COORD_W'(H_START);
  localparam logic [COORD_W-1:0] V_START_W = COORD_W'(V_START);

  logic [COORD_W-1:0] cnt_h;
  logic [COORD_W-1:0] cnt_v;
  logic               h_sync_c;
  logic               v_sync_c;
  logic               h_act_c;
  logic               v_act_c;
  logic               h_wrap_c;
  logic               h_req_c;
  logic               act_c;
  rgb888_t            pix_colour_c;

  assign h_wrap_c = (cnt_h == H_LAST);

  vga_sync_cnt #(
    .TOTAL    (H_TOTAL),
    .SYNC     (H_SYNC),
    .START    (H_START),
    .VALID    (H_VALID),
    .SYNC_POL (SYNC_POL)
  ) u_h_cnt (
    .clk    (vga_clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .cnt    (cnt_h),
    .sync_c (h_sync_c),
    .act_c  (h_act_c)
  );

  vga_sync_cnt #(
    .TOTAL    (V_TOTAL),
    .SYNC     (V_SYNC),
    .START    (V_START),
    .VALID    (V_VALID),
    .SYNC_POL (SYNC_POL)
  ) u_v_cnt (
    .clk    (vga_clk),
    .rst_n  (rst_n),
    .en     (h_wrap_c),
    .cnt    (cnt_v),
    .sync_c (v_sync_c),
    .act_c  (v_act_c)
  );

  // Requests lead the active window by one clock to cover the picture stage register.
  assign h_req_c = (cnt_h >= H_REQ_LO) && (cnt_h < H_REQ_HI);
  assign pix_req = h_req_c && v_act_c;
  assign pos_x   = pix_req ? cnt_h - H_REQ_LO  : '0;
  assign pos_y   = pix_req ? cnt_v - V_START_W : '0;
  assign act_c   = h_act_c && v_act_c;

  // Colour for the current pixel: returned data or test bars, black in blanking.
  always_comb begin
    pix_colour_c = '0;
    if (act_c) begin
      pix_colour_c = pos_data;
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_en)
        pix_colour_c = bar_colour(cnt_h - H_START_W);
`endif
    end
  end

  // Output stage: sync, DE and colour all lag the counters by one clock.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      vga_de      <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync_c;
      vsync       <= v_sync_c;
      vga_de      <= act_c;
      rgb         <= pix_colour_c;
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
    end
  end

endmodule
